irq_ctrl: RTL

//  Consumer side of peripheral interrupt flags (timer TCON[2], UART, ...).

---
 rtl/irq_if.sv | 29 ++
 rtl/irq_ctrl.sv | 117 +++++++++++
 2 files changed

// File: rtl/irq_if.sv
// Interrupt controller bus: peripheral flags, CPU handshake and status outputs.
// The master side (CPU/peripheral environment) drives flags and handshakes;
// the slave side (irq_ctrl) returns the request, id, clears and status.
interface irq_if #(
  parameter int NUM_SRC = 4,
  parameter int ID_W    = 2,
  parameter int CNT_W   = 16
);
  logic [NUM_SRC-1:0] irq_src;
  logic [NUM_SRC-1:0] irq_mask;
  logic               pc_kernel;
  logic               irq_ack;
  logic               eret;
  logic               irq_req;
  logic [ID_W-1:0]    irq_id;
  logic [NUM_SRC-1:0] src_clr;
  logic               in_service;
  logic [CNT_W-1:0]   miss_cnt;

  modport master (
    output irq_src, irq_mask, pc_kernel, irq_ack, eret,
    input  irq_req, irq_id, src_clr, in_service, miss_cnt
  );

  modport slave (
    input  irq_src, irq_mask, pc_kernel, irq_ack, eret,
    output irq_req, irq_id, src_clr, in_service, miss_cnt
  );
endinterface

// File: rtl/irq_ctrl.sv
// Interrupt controller: edge-detects peripheral flags, holds them pending,
// raises one masked, lowest-index-first request to the CPU, and pulses a
// clear back to the serviced source once the CPU acknowledges.
module irq_ctrl #(
  parameter int NUM_SRC = 4,
  parameter int ID_W    = 2,
  parameter int CNT_W   = 16
) (
  input  logic  clk_in,
  input  logic  reset,
  irq_if.slave  bus
);
  localparam int SUM_W = CNT_W + 1;

  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

  state_t             state_q, state_d;
  logic [NUM_SRC-1:0] pend_q, pend_d;
  logic [NUM_SRC-1:0] prev_q, prev_d;
  logic [NUM_SRC-1:0] src_clr_q, src_clr_d;
  logic               armed_q, armed_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic [CNT_W-1:0]   miss_q, miss_d;

  logic [NUM_SRC-1:0] rise;
  logic [NUM_SRC-1:0] cand;
  logic [NUM_SRC-1:0] clr;
  logic [NUM_SRC-1:0] miss_vec;
  logic [ID_W-1:0]    winner;
  logic               any_cand;
  logic [SUM_W-1:0]   miss_sum;

  // A level already high when reset releases is not an edge: the first
  // cycle after reset only loads the previous-sample register.
  assign rise = armed_q ? (bus.irq_src & ~prev_q) : '0;
  assign cand = pend_q & bus.irq_mask;

  // Lowest enabled pending index wins.
  always_comb begin
    winner   = '0;
    any_cand = |cand;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (cand[i]) winner = ID_W'(i);
    end
  end

  // Request/service state machine; clr marks the source being acknowledged.
  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    clr     = '0;
    case (state_q)
      IDLE: begin
        if (any_cand && !bus.pc_kernel) begin
          state_d = REQ;
          id_d    = winner;
        end
      end
      REQ: begin
        if (bus.irq_ack) begin
          state_d = SERVICE;
          clr     = NUM_SRC'(1) << id_q;
        end else if (!cand[id_q]) begin
          state_d = IDLE;
        end
      end
      SERVICE: begin
        if (bus.eret) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Pending set/clear (a new edge beats a same-cycle clear) and the
  // saturating count of edges that landed on an already pending source.
  always_comb begin
    pend_d    = '0;
    miss_vec  = '0;
    miss_sum  = {1'b0, miss_q};
    for (int i = 0; i < NUM_SRC; i++) begin
      pend_d[i]   = rise[i] | (pend_q[i] & ~clr[i]);
      miss_vec[i] = rise[i] & pend_q[i] & ~clr[i];
      miss_sum    = miss_sum + SUM_W'(miss_vec[i]);
    end
    miss_d    = miss_sum[CNT_W] ? '1 : miss_sum[CNT_W-1:0];
    prev_d    = bus.irq_src;
    armed_d   = 1'b1;
    src_clr_d = clr;
  end

  // State and datapath registers.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      pend_q    <= '0;
      prev_q    <= '0;
      src_clr_q <= '0;
      armed_q   <= 1'b0;
      id_q      <= '0;
      miss_q    <= '0;
    end else begin
      state_q   <= state_d;
      pend_q    <= pend_d;
      prev_q    <= prev_d;
      src_clr_q <= src_clr_d;
      armed_q   <= armed_d;
      id_q      <= id_d;
      miss_q    <= miss_d;
    end
  end

  assign bus.irq_req    = (state_q == REQ);
  assign bus.in_service = (state_q == SERVICE);
  assign bus.irq_id     = id_q;
  assign bus.src_clr    = src_clr_q;
  assign bus.miss_cnt   = miss_q;
endmodule
